// File: rtl/dm_pkg.sv
// dm_pkg: shared constants and types for the data-memory access controller
//   SZ_*          access size encodings carried on cpu_size
//   state_t       controller FSM states
//   req_t         request fields latched on acceptance
//   MEM_WORDS_DEF default memory depth in words
package dm_pkg;
    localparam int MEM_WORDS_DEF = 3072;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;
endpackage

// File: rtl/dm_byte_lane.sv
// dm_byte_lane: little-endian lane merge for stores and lane extract/extend for loads
//   word_i   in  32  current memory word
//   data_i   in  32  right-aligned store data
//   size_i   in  2   access size
//   offset_i in  2   byte offset within the word
//   sign_i   in  1   1 = sign-extend loads
//   store_o  out 32  word to write back
//   load_o   out 32  extended load value
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        sign_i,
    output logic [31:0] store_o,
    output logic [31:0] load_o
);
    logic [31:0] bmask, hmask;
    logic [7:0]  bv;
    logic [15:0] hv;

    always_comb begin
        bmask = 32'hFF << {offset_i, 3'b000};
        hmask = 32'hFFFF << {offset_i[1], 4'b0000};
        bv = 8'(word_i >> {offset_i, 3'b000});
        hv = 16'(word_i >> {offset_i[1], 4'b0000});
        // replicate the store data into every lane, then let the mask pick one
        store_o = size_i == SZ_WORD ? data_i :
                  size_i == SZ_HALF ? (word_i & ~hmask) | ({2{data_i[15:0]}} & hmask) :
                                      (word_i & ~bmask) | ({4{data_i[7:0]}} & bmask);
        load_o  = size_i == SZ_WORD ? word_i :
                  size_i == SZ_HALF ? {{16{sign_i & hv[15]}}, hv} :
                                      {{24{sign_i & bv[7]}}, bv};
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage load/store initiator for a word-only data memory
//   clk, reset                 clock, async active-high reset
//   cpu_req/cpu_ready          request handshake (accepted only in IDLE)
//   cpu_we/size/sign/addr/wdata/pc  request fields
//   cpu_done/cpu_err/cpu_rdata one-cycle response
//   mem_addr/we/wdata/rdata/pc word memory port, combinational read
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_pc
);
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] st_word, ld_word;
    logic        bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign bad = cpu_size == 2'b11 ||
                 (cpu_size == SZ_HALF && cpu_addr[0]) ||
                 (cpu_size == SZ_WORD && cpu_addr[1:0] != 2'b00) ||
                 {1'b0, cpu_addr} >= LIMIT;

    // sub-word stores read first so the untouched lanes can be merged back
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_IDLE: if (cpu_req) begin
                req_d = '{we: cpu_we, size: cpu_size, sign: cpu_sign, err: bad,
                          addr: cpu_addr, wdata: cpu_wdata, pc: cpu_pc};
                state_d = bad ? S_RESP : !cpu_we ? S_RD : cpu_size == SZ_WORD ? S_WR : S_RD;
            end
            S_RD: begin
                rbuf_d  = mem_rdata;
                state_d = req_q.we ? S_WR : S_RESP;
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    dm_byte_lane u_lane (
        .word_i   (rbuf_q),
        .data_i   (req_q.wdata),
        .size_i   (req_q.size),
        .offset_i (req_q.addr[1:0]),
        .sign_i   (req_q.sign),
        .store_o  (st_word),
        .load_o   (ld_word)
    );

    // mem_we depends on state alone so an async reset drops it immediately
    always_comb begin
        cpu_ready = state_q == S_IDLE;
        cpu_done  = state_q == S_RESP;
        cpu_err   = cpu_done && req_q.err;
        cpu_rdata = cpu_done && !req_q.we && !req_q.err ? ld_word : '0;
        mem_we    = state_q == S_WR;
        mem_addr  = state_q == S_IDLE || req_q.err ? '0 : {req_q.addr[31:2], 2'b00};
        mem_wdata = st_word;
        mem_pc    = req_q.pc;
    end
endmodule
